am_key_receiver: RTL and testbench
==================================

Name: am_key_receiver

Overview:
- Bench/monitor-side demodulator for the AM antenna leak channel: samples the single-bit antenna line and recovers the 128-bit key carried on it.
- Sits beside the AES top in the T400 test environment; its antenna input is driven by the top-level antenna output. It provides a cycle-accurate check that the leak channel carries the key and counts frame errors.
- Symbol format:
  - symbol = SYMBOL_CYCLES clocks;
  - '1' = carrier present (line toggling);
  - '0' = line static.
  - frame = 1 start symbol ('1'), then 128 data symbols key[0] first, then 1 stop symbol ('0').

Parameters:
- SYMBOL_CYCLES, 64, clocks per symbol window (≥8).
- CARRIER_THRESH, 8, minimum edges in a window to decode '1'.
- IDLE_SYMBOLS, 2, consecutive '0' windows required before a start is accepted.
- KEY_W, 128, key/frame payload width.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- antena_in  input  1  antenna line from the transmitter
- key_out  output  KEY_W  last correctly framed recovered key
- key_valid  output  1  one-cycle pulse when key_out updates
- busy  output  1  high in START/DATA/STOP
- frame_err  output  1  one-cycle pulse on bad start or stop symbol
- err_count  output  8  saturating frame-error counter

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: all outputs 0; FSM = IDLE; synchronizer flops 0; all counters 0.
- Input path:
  - 2-flop synchronizer, then a previous-sample flop.
  - edge = sync XOR prev. Adds 3 cycles of input latency; all window timing is relative to the synchronized signal.
- Window counter: cycle_cnt runs 0..SYMBOL_CYCLES-1 and wraps. edge_cnt accumulates edges, saturating at 2^clog2(SYMBOL_CYCLES)-1.
  - At wrap: sym = (edge_cnt ≥ CARRIER_THRESH); edge_cnt clears. An edge in the wrap cycle counts toward the next window.
- FSM:
  - IDLE:
    - Free-running windows; quiet_cnt counts consecutive sym=0 and resets on sym=1.
    - When quiet_cnt reaches IDLE_SYMBOLS → ARMED.
  - ARMED:
    - Windows halted; cycle_cnt held at 0.
    - First edge → START. cycle_cnt restarts at 1 and that edge is counted, so windows align to carrier onset.
  - START:
    - At wrap: sym=1 → DATA, bit_idx=0.
    - sym=0 → pulse frame_err, go to IDLE with quiet_cnt=0.
  - DATA:
    - At each wrap: shift_reg[bit_idx] ← sym, bit_idx++.
    - After bit_idx = KEY_W-1 → STOP.
  - STOP:
    - At wrap, sym=0: key_out ← shift_reg next cycle, key_valid pulses that same cycle, then IDLE with quiet_cnt=1 (the stop counts as quiet).
    - sym=1: frame_err pulses, key_out is unchanged, go to IDLE with quiet_cnt=0.
- Latency: key_valid is asserted 1 clock after the stop window closes, i.e. (KEY_W+2)*SYMBOL_CYCLES+1 clocks after the first synchronized edge.
- err_count increments on each frame_err pulse and saturates at 255; it does not wrap.
- busy = (state ∈ {START, DATA, STOP}).
- key_out holds its value indefinitely between frames. It is never partially updated.
- Reset mid-frame: immediate abort; key_out is cleared to 0 and no key_valid pulse is produced.
- Continuous carrier (no quiet gap): the receiver never leaves IDLE, so no key_valid and no frame_err. This prevents mid-stream lock.
- A line stuck high or low produces no edges and is decoded as '0'.

Decomposition:
- Shared package am_link_pkg holds values common with the transmitter:
  - SYMBOL_CYCLES and KEY_W defaults;
  - start/stop symbol constants;
  - bit-order constant (LSB first);
  - FSM state enum typedef (IDLE, ARMED, START, DATA, STOP).
- One natural sub-module: am_symbol_detector (synchronizer, edge detect, window counter, threshold compare). It has outputs sym and sym_strobe plus an align/hold input driven by the FSM.
- The FSM, shift register and error counter stay in am_key_receiver.

Test Plan:
- Clean frame with key=128'h000102030405060708090A0B0C0D0E0F: 3 quiet symbols, start, data with '1' as toggling every clock, stop. Required: one key_valid, key_out equal to that key, frame_err=0, busy high for exactly 130*64 cycles.
- Weak carrier: a '1' symbol with 7 edges/window (below CARRIER_THRESH=8) on bit 5 of an all-ones key → key_out = all ones except bit 5 = 0. With 8 edges → bit decodes as 1.
- Bad stop: carrier present in the stop window → frame_err pulse, err_count=1, key_out keeps its previous value, no key_valid.
- Continuous carrier from reset for 1000 symbols → state stays IDLE, no key_valid, no frame_err. Then 2 quiet symbols and a valid frame → key recovered correctly.
- Async reset asserted at data bit 60 → all outputs 0 immediately (same cycle, without a clock edge). A following clean frame with key=128'hFFFF...0000 is recovered exactly.
- 300 consecutive bad-start frames (a single edge, then quiet) → err_count saturates at 255, frame_err pulses 300 times.

Source files
------------

// File: rtl/am_link_pkg.sv
// rtl/am_link_pkg.sv - values shared between the AM leak-channel transmitter and receiver
package am_link_pkg;

    localparam int SYMBOL_CYCLES_DEF = 64;
    localparam int KEY_W_DEF         = 128;

    // Framing symbols: carrier marks the start, silence marks the stop
    localparam logic START_SYM = 1'b1;
    localparam logic STOP_SYM  = 1'b0;

    // Payload is sent key[0] first
    localparam bit LSB_FIRST = 1'b1;

    typedef enum logic [2:0] {
        AM_IDLE  = 3'd0,
        AM_ARMED = 3'd1,
        AM_START = 3'd2,
        AM_DATA  = 3'd3,
        AM_STOP  = 3'd4
    } am_state_e;

endpackage

// File: rtl/am_key_receiver_if.sv
// rtl/am_key_receiver_if.sv - antenna input and recovered-key outputs of the AM key receiver
interface am_key_receiver_if #(
    parameter int KEY_W = am_link_pkg::KEY_W_DEF
) ();

    logic             antena_in;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             busy;
    logic             frame_err;
    logic [7:0]       err_count;

    // Transmitter / monitor side
    modport master (
        output antena_in,
        input  key_out, key_valid, busy, frame_err, err_count
    );

    // Receiver side
    modport slave (
        input  antena_in,
        output key_out, key_valid, busy, frame_err, err_count
    );

endinterface

// File: rtl/am_symbol_detector.sv
// rtl/am_symbol_detector.sv - synchronizer, edge detector and per-window carrier threshold
module am_symbol_detector
    import am_link_pkg::*;
#(
    parameter int SYMBOL_CYCLES  = SYMBOL_CYCLES_DEF,
    parameter int CARRIER_THRESH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    input  logic hold,
    output logic edge_det,
    output logic sym,
    output logic sym_strobe
);

    localparam int            CW     = $clog2(SYMBOL_CYCLES);
    localparam logic [CW-1:0] LAST   = CW'(SYMBOL_CYCLES - 1);
    localparam logic [CW-1:0] EMAX   = '1;
    localparam logic [CW-1:0] THRESH = CW'(CARRIER_THRESH);

    logic          sync1, sync2, prev;
    logic [CW-1:0] cycle_cnt;
    logic [CW-1:0] edge_cnt;

    assign edge_det = sync2 ^ prev;

    // Two-flop synchronizer plus the previous-sample flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= line_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Window counter and edge accumulator; sym/sym_strobe are registered one cycle after the wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt  <= '0;
            edge_cnt   <= '0;
            sym        <= 1'b0;
            sym_strobe <= 1'b0;
        end else if (hold) begin
            // Parked while armed; the first edge becomes cycle 0 of a freshly aligned window
            cycle_cnt  <= edge_det ? CW'(1) : '0;
            edge_cnt   <= edge_det ? CW'(1) : '0;
            sym_strobe <= 1'b0;
        end else begin
            sym_strobe <= (cycle_cnt == LAST);
            if (cycle_cnt == LAST) begin
                cycle_cnt <= '0;
                sym       <= (edge_cnt >= THRESH);
                // An edge landing in the wrap cycle belongs to the next window
                edge_cnt  <= edge_det ? CW'(1) : '0;
            end else begin
                cycle_cnt <= cycle_cnt + CW'(1);
                if (edge_det && (edge_cnt != EMAX)) begin
                    edge_cnt <= edge_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/am_key_receiver.sv
// rtl/am_key_receiver.sv - frames AM leak-channel symbols into a recovered 128-bit key
module am_key_receiver
    import am_link_pkg::*;
#(
    parameter int SYMBOL_CYCLES  = SYMBOL_CYCLES_DEF,
    parameter int CARRIER_THRESH = 8,
    parameter int IDLE_SYMBOLS   = 2,
    parameter int KEY_W          = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    am_key_receiver_if.slave bus
);

    localparam int            BW        = $clog2(KEY_W);
    localparam logic [BW-1:0] LAST_BIT  = BW'(KEY_W - 1);
    localparam logic [7:0]    QUIET_REQ = 8'(IDLE_SYMBOLS);

    localparam logic [2:0] S_IDLE  = AM_IDLE;
    localparam logic [2:0] S_ARMED = AM_ARMED;
    localparam logic [2:0] S_START = AM_START;
    localparam logic [2:0] S_DATA  = AM_DATA;
    localparam logic [2:0] S_STOP  = AM_STOP;

    logic [2:0]       state;
    logic [7:0]       quiet_cnt;
    logic [BW-1:0]    bit_idx;
    logic [BW-1:0]    wr_idx;
    logic [KEY_W-1:0] shift_reg;
    logic [KEY_W-1:0] key_q;
    logic             key_valid_q;
    logic             frame_err_q;
    logic [7:0]       err_cnt;
    logic             sym, sym_strobe, edge_det;
    logic             hold;

    assign hold   = (state == S_ARMED);
    assign wr_idx = LSB_FIRST ? bit_idx : (LAST_BIT - bit_idx);

    am_symbol_detector #(
        .SYMBOL_CYCLES  (SYMBOL_CYCLES),
        .CARRIER_THRESH (CARRIER_THRESH)
    ) u_det (
        .clk        (clk),
        .rst        (rst),
        .line_in    (bus.antena_in),
        .hold       (hold),
        .edge_det   (edge_det),
        .sym        (sym),
        .sym_strobe (sym_strobe)
    );

    // Frame FSM: quiet gap, carrier-aligned start, payload capture, stop check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            quiet_cnt   <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Only a run of silent windows arms the receiver, so it cannot lock mid-stream
                    if (sym_strobe) begin
                        if (sym) begin
                            quiet_cnt <= '0;
                        end else if ((quiet_cnt + 8'd1) >= QUIET_REQ) begin
                            quiet_cnt <= '0;
                            state     <= S_ARMED;
                        end else begin
                            quiet_cnt <= quiet_cnt + 8'd1;
                        end
                    end
                end
                S_ARMED: begin
                    if (edge_det) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (sym_strobe) begin
                        if (sym == START_SYM) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            frame_err_q <= 1'b1;
                            quiet_cnt   <= '0;
                            state       <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (sym_strobe) begin
                        shift_reg[wr_idx] <= sym;
                        if (bit_idx == LAST_BIT) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (sym_strobe) begin
                        state <= S_IDLE;
                        if (sym == STOP_SYM) begin
                            key_q       <= shift_reg;
                            key_valid_q <= 1'b1;
                            // The stop window itself was silent
                            quiet_cnt   <= 8'd1;
                        end else begin
                            frame_err_q <= 1'b1;
                            quiet_cnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Saturating frame-error counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (frame_err_q && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign bus.key_out   = key_q;
    assign bus.key_valid = key_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_count = err_cnt;
    assign bus.busy      = (state == S_START) || (state == S_DATA) || (state == S_STOP);

endmodule

// File: tb/tb_am_key_receiver.sv
// tb/tb_am_key_receiver.sv - directed bench for the AM key receiver
module tb_am_key_receiver;

    localparam int SC    = 16;
    localparam int KEY_W = 128;

    typedef struct {
        logic [KEY_W-1:0] key;
        int               weak_bit;
        int               weak_edges;
        bit               full_toggle;
        bit               bad_stop;
        int               exp_valid;
        logic [KEY_W-1:0] exp_key;
        int               exp_ferr;
        int               exp_errc;
    } vec_t;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_valid = 0;
    int   n_ferr = 0;
    int   n_busy = 0;
    int   valid_cyc = 0;
    int   last_sym_cyc = 0;
    int   start_cyc = 0;

    vec_t vecs [4];

    am_key_receiver_if #(.KEY_W(KEY_W)) bus ();

    am_key_receiver #(
        .SYMBOL_CYCLES  (SC),
        .CARRIER_THRESH (8),
        .IDLE_SYMBOLS   (2),
        .KEY_W          (KEY_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (bus.key_valid) begin
            n_valid   = n_valid + 1;
            valid_cyc = cyc;
        end
        if (bus.frame_err) n_ferr = n_ferr + 1;
        if (bus.busy) n_busy = n_busy + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    task automatic check(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One symbol window: toggle the line on the first n_edges cycles when b is set
    task automatic sym_out(input bit b, input int n_edges);
        for (int i = 0; i < SC; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) last_sym_cyc = cyc;
            if (b && (i < n_edges)) bus.antena_in = ~bus.antena_in;
        end
    endtask

    // Quiet preamble, start, payload key[0] first, stop, one quiet tail window.
    // Shaped '1' symbols leave the last cycle static, because the detector credits
    // an edge in a window's last cycle to the next window.
    task automatic send_frame(input logic [KEY_W-1:0] key, input int weak_bit, input int weak_edges,
                              input bit full_toggle, input bit bad_stop);
        int ne;
        ne = full_toggle ? SC : SC - 1;
        repeat (3) sym_out(1'b0, 0);
        sym_out(1'b1, ne);
        start_cyc = last_sym_cyc;
        for (int i = 0; i < KEY_W; i++) begin
            if (i == weak_bit) sym_out(key[i], weak_edges);
            else sym_out(key[i], ne);
        end
        sym_out(bad_stop, ne);
        sym_out(1'b0, 0);
    endtask

    initial begin
        int sv, sf, sb;
        logic [KEY_W-1:0] pat;

        vecs[0] = '{128'h000102030405060708090A0B0C0D0E0F, -1, 0, 1'b1, 1'b0,
                    1, 128'h000102030405060708090A0B0C0D0E0F, 0, 0};
        vecs[1] = '{{KEY_W{1'b1}}, 5, 7, 1'b0, 1'b0, 1, ~(128'h20), 0, 0};
        vecs[2] = '{{KEY_W{1'b1}}, 5, 8, 1'b0, 1'b0, 1, {KEY_W{1'b1}}, 0, 0};
        vecs[3] = '{128'h0123456789ABCDEFFEDCBA9876543210, -1, 0, 1'b0, 1'b1,
                    0, {KEY_W{1'b1}}, 1, 1};

        bus.antena_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset key_out", bus.key_out, '0);
        check("reset key_valid", KEY_W'(bus.key_valid), '0);
        check("reset busy", KEY_W'(bus.busy), '0);
        check("reset frame_err", KEY_W'(bus.frame_err), '0);
        check("reset err_count", KEY_W'(bus.err_count), '0);
        @(negedge clk);
        rst = 1'b0;

        // Continuous carrier straight out of reset: never arms
        sv = n_valid; sf = n_ferr; sb = n_busy;
        repeat (1000) sym_out(1'b1, SC);
        check("carrier key_valid count", KEY_W'(n_valid - sv), 0);
        check("carrier frame_err count", KEY_W'(n_ferr - sf), 0);
        check("carrier busy cycles", KEY_W'(n_busy - sb), 0);
        sv = n_valid;
        send_frame(128'hDEADBEEF_0BADF00D_CAFEBABE_12345678, -1, 0, 1'b1, 1'b0);
        check("post-carrier key_valid count", KEY_W'(n_valid - sv), 1);
        check("post-carrier key_out", bus.key_out, 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678);

        for (int v = 0; v < 4; v++) begin
            sv = n_valid; sf = n_ferr; sb = n_busy;
            send_frame(vecs[v].key, vecs[v].weak_bit, vecs[v].weak_edges,
                       vecs[v].full_toggle, vecs[v].bad_stop);
            check($sformatf("vec%0d key_valid count", v), KEY_W'(n_valid - sv), KEY_W'(vecs[v].exp_valid));
            check($sformatf("vec%0d key_out", v), bus.key_out, vecs[v].exp_key);
            check($sformatf("vec%0d frame_err count", v), KEY_W'(n_ferr - sf), KEY_W'(vecs[v].exp_ferr));
            check($sformatf("vec%0d err_count", v), KEY_W'(bus.err_count), KEY_W'(vecs[v].exp_errc));
            check($sformatf("vec%0d busy cycles", v), KEY_W'(n_busy - sb), KEY_W'(130 * SC));
            if (vecs[v].exp_valid != 0) begin
                check($sformatf("vec%0d key_valid latency", v), KEY_W'(valid_cyc - start_cyc),
                      KEY_W'(130 * SC + 3));
            end
        end

        // Asynchronous reset in the middle of data bit 60
        sv = n_valid;
        pat = {16{8'hA5}};
        repeat (3) sym_out(1'b0, 0);
        sym_out(1'b1, SC - 1);
        for (int i = 0; i < 60; i++) sym_out(pat[i], SC - 1);
        repeat (5) @(posedge clk);
        #1;
        check("midframe busy before reset", KEY_W'(bus.busy), 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async reset key_out", bus.key_out, '0);
        check("async reset busy", KEY_W'(bus.busy), 0);
        check("async reset err_count", KEY_W'(bus.err_count), 0);
        check("async reset key_valid", KEY_W'(bus.key_valid), 0);
        check("async reset frame_err", KEY_W'(bus.frame_err), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("aborted frame key_valid count", KEY_W'(n_valid - sv), 0);
        sv = n_valid;
        send_frame(128'hFFFFFFFFFFFFFFFF0000000000000000, -1, 0, 1'b1, 1'b0);
        check("post-reset key_valid count", KEY_W'(n_valid - sv), 1);
        check("post-reset key_out", bus.key_out, 128'hFFFFFFFFFFFFFFFF0000000000000000);

        // 300 bad starts: single edge, then enough silence to re-arm
        repeat (3) sym_out(1'b0, 0);
        sv = n_valid; sf = n_ferr;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1 bus.antena_in = ~bus.antena_in;
            repeat (3 * SC + 4) @(posedge clk);
            #1;
            if (i == 253) check("err_count after 254 bad starts", KEY_W'(bus.err_count), 254);
            if (i == 254) check("err_count after 255 bad starts", KEY_W'(bus.err_count), 255);
        end
        check("bad start frame_err count", KEY_W'(n_ferr - sf), 300);
        check("err_count saturated", KEY_W'(bus.err_count), 255);
        check("bad start key_valid count", KEY_W'(n_valid - sv), 0);
        check("bad start key_out held", bus.key_out, 128'hFFFFFFFFFFFFFFFF0000000000000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
